// File: rtl/func_sweep.sv
// Exhaustive truth-table sweeper for a 5-input combinational function.
// Optional golden-table comparator and match port are enabled with FUNC_SWEEP_CMP_EN.
module func_sweep #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [31:0] EXPECTED = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_out,
  output logic [5:0]  ones_cnt
`ifdef FUNC_SWEEP_CMP_EN
  ,
  output logic        match
`endif
);

  // Settle count must fit the 4-bit counter and be nonzero.
  if ((SETTLE < 1) || (SETTLE > 15) || ($bits(EXPECTED) != 32)) begin : g_bad_settle
    $fatal(1, "func_sweep: SETTLE must be in 1..15");
  end

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  idx_r, idx_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] table_r, table_s;
  logic [5:0]  ones_r, ones_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
`ifdef FUNC_SWEEP_CMP_EN
  logic        match_r, match_s;
`endif

  // Next-state and next-register values; every output is taken from a register.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    table_s = table_r;
    ones_s  = ones_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
`ifdef FUNC_SWEEP_CMP_EN
    match_s = match_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          idx_s   = 5'd0;
          cnt_s   = 4'd0;
          table_s = 32'd0;
          ones_s  = 6'd0;
          busy_s  = 1'b1;
`ifdef FUNC_SWEEP_CMP_EN
          match_s = 1'b0;
`endif
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r + 4'd1;
        if (cnt_r == SETTLE_LAST) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SAMPLE: begin
        table_s[idx_r] = f_in;
        ones_s         = ones_r + {5'd0, f_in};
        // The last vector leaves the sweep instead of wrapping idx.
        if (idx_r == 5'd31) begin
          busy_s  = 1'b0;
          done_s  = 1'b1;
`ifdef FUNC_SWEEP_CMP_EN
          match_s = (table_s == EXPECTED);
`endif
          state_s = ST_DONE;
        end else begin
          idx_s   = idx_r + 5'd1;
          cnt_s   = 4'd0;
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 5'd0;
      cnt_r   <= 4'd0;
      table_r <= 32'd0;
      ones_r  <= 6'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef FUNC_SWEEP_CMP_EN
      match_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      table_r <= table_s;
      ones_r  <= ones_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
`ifdef FUNC_SWEEP_CMP_EN
      match_r <= match_s;
`endif
    end
  end

  assign {a, b, c, d, e} = idx_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign table_out       = table_r;
  assign ones_cnt        = ones_r;
`ifdef FUNC_SWEEP_CMP_EN
  assign match           = match_r;
`endif

endmodule

// File: tb/tb_func_sweep.sv
// Directed self-checking bench for func_sweep: SETTLE=1 and SETTLE=3 instances.
module tb_func_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start1, start3;
  logic [2:0]  sel1, sel3;
  logic        f1, f3;
  logic        a1, b1, c1, d1, e1, busy1, done1;
  logic        a3, b3, c3, d3, e3, busy3, done3;
  logic [31:0] tab1, tab3;
  logic [5:0]  ones1, ones3;
`ifdef FUNC_SWEEP_CMP_EN
  logic        match1, match3;
`endif

  int checks = 0;
  int errors = 0;

  // Functions under test, selected per instance; v = {a,b,c,d,e}.
  function automatic logic pick(input logic [2:0] s, input logic [4:0] v);
    case (s)
      3'd0:    pick = 1'b0;
      3'd1:    pick = 1'b1;
      3'd2:    pick = v[0];
      3'd3:    pick = v[4];
      3'd4:    pick = v[2];
      3'd5:    pick = (v[4] & v[3]) | (v[2] ^ v[0]);
      default: pick = 1'b0;
    endcase
  endfunction

  always_comb f1 = pick(sel1, {a1, b1, c1, d1, e1});
  always_comb f3 = pick(sel3, {a3, b3, c3, d3, e3});

  func_sweep #(.SETTLE(1), .EXPECTED(32'hFF5A5A5A)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1),
    .busy(busy1), .done(done1), .table_out(tab1), .ones_cnt(ones1)
`ifdef FUNC_SWEEP_CMP_EN
    , .match(match1)
`endif
  );

  func_sweep #(.SETTLE(3), .EXPECTED(32'h00000001)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .f_in(f3),
    .a(a3), .b(b3), .c(c3), .d(d3), .e(e3),
    .busy(busy3), .done(done3), .table_out(tab3), .ones_cnt(ones3)
`ifdef FUNC_SWEEP_CMP_EN
    , .match(match3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full sweep on the selected instance; restart_idx >= 0 re-pulses start mid-sweep.
  task automatic run_sweep(input int which, input int restart_idx, input logic [31:0] exp_tab,
                           input logic [5:0] exp_ones, input int exp_edges, input string tag);
    int         edges = 0;
    int         gaps  = 0;
    logic       dn = 1'b0;
    logic       bz;
    logic [4:0] v;
    if (which == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      start1 = 1'b0; start3 = 1'b0;
      edges++;
      dn = (which == 1) ? done1 : done3;
      bz = (which == 1) ? busy1 : busy3;
      v  = (which == 1) ? {a1, b1, c1, d1, e1} : {a3, b3, c3, d3, e3};
      if (dn) break;
      if (!bz) gaps++;
      if ((restart_idx >= 0) && (v == restart_idx[4:0])) begin
        if (which == 1) start1 = 1'b1; else start3 = 1'b1;
      end
    end
    chk({tag, "_done_edge"}, edges, exp_edges);
    chk({tag, "_done"}, {31'd0, dn}, 32'd1);
    chk({tag, "_busy_gaps"}, gaps, 32'd0);
    chk({tag, "_table"}, (which == 1) ? tab1 : tab3, exp_tab);
    chk({tag, "_ones"}, {26'd0, (which == 1) ? ones1 : ones3}, {26'd0, exp_ones});
    chk({tag, "_busy_at_done"}, {31'd0, (which == 1) ? busy1 : busy3}, 32'd0);
    // start during DONE must be dropped, not queued.
    if (which == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    chk({tag, "_done_pulse_end"}, {31'd0, (which == 1) ? done1 : done3}, 32'd0);
    chk({tag, "_idle_vec"}, {27'd0, (which == 1) ? {a1, b1, c1, d1, e1} : {a3, b3, c3, d3, e3}},
        32'd31);
    @(posedge clk); #1;
    chk({tag, "_no_queue"}, {31'd0, (which == 1) ? busy1 : busy3}, 32'd0);
    chk({tag, "_table_hold"}, (which == 1) ? tab1 : tab3, exp_tab);
  endtask

  initial begin
    int done_seen;
    int hit;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; sel1 = 3'd0; sel3 = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec1", {27'd0, a1, b1, c1, d1, e1}, 32'd0);
    chk("rst_flags1", {30'd0, busy1, done1}, 32'd0);
    chk("rst_table1", tab1, 32'd0);
    chk("rst_ones3", {26'd0, ones3}, 32'd0);
    chk("rst_flags3", {30'd0, busy3, done3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    sel1 = 3'd1;
    run_sweep(1, -1, 32'hFFFFFFFF, 6'd32, 64, "all_ones");
    sel1 = 3'd2;
    run_sweep(1, -1, 32'hAAAAAAAA, 6'd16, 64, "f_eq_e");
    sel1 = 3'd3;
    run_sweep(1, -1, 32'hFFFF0000, 6'd16, 64, "f_eq_a");
    sel3 = 3'd0;
    run_sweep(3, -1, 32'h00000000, 6'd0, 128, "settle3_zero");
`ifdef FUNC_SWEEP_CMP_EN
    chk("match_flipped", {31'd0, match3}, 32'd0);
`endif
    sel1 = 3'd4;
    run_sweep(1, 10, 32'hF0F0F0F0, 6'd16, 64, "restart_ignored");

    // Abort a sweep at idx 17 with an asynchronous reset.
    sel1 = 3'd5;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    hit = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if ({a1, b1, c1, d1, e1} == 5'd17) begin
        hit = 1;
        break;
      end
    end
    chk("reach_idx17", hit, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_vec", {27'd0, a1, b1, c1, d1, e1}, 32'd0);
    chk("abort_table", tab1, 32'd0);
    chk("abort_ones", {26'd0, ones1}, 32'd0);
    chk("abort_flags", {30'd0, busy1, done1}, 32'd0);
    done_seen = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (done1) done_seen++;
    end
    chk("abort_no_done", done_seen, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_vec", {27'd0, a1, b1, c1, d1, e1}, 32'd0);
    run_sweep(1, -1, 32'hFF5A5A5A, 6'd20, 64, "after_reset");
`ifdef FUNC_SWEEP_CMP_EN
    chk("match_golden", {31'd0, match1}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
